// File: rtl/ifetch_pkg.sv
// Shared constants and the fetch-buffer entry layout for the instruction fetch stage.
package ifetch_pkg;

    localparam logic [31:0] RstPC    = 32'h0000_0000;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic        fault;
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction bus, redirect and decode handshake bundle for ifetch.
// ibus_err_i exists only when IFETCH_FAULT_EN is defined.
interface ifetch_if;

    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
`ifdef IFETCH_FAULT_EN
    logic        ibus_err_i;
`endif
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] addr_o;
    logic        fault_o;
    logic        inst_ready_i;

    modport master (
        output ibus_req_o, ibus_addr_o,
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
`ifdef IFETCH_FAULT_EN
        input  ibus_err_i,
`endif
        input  redirect_i, redirect_pc_i, inst_ready_i,
        output inst_valid_o, inst_o, addr_o, fault_o
    );

    modport slave (
        input  ibus_req_o, ibus_addr_o,
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i,
`ifdef IFETCH_FAULT_EN
        output ibus_err_i,
`endif
        output redirect_i, redirect_pc_i, inst_ready_i,
        input  inst_valid_o, inst_o, addr_o, fault_o
    );

endinterface

// File: rtl/if_fifo.sv
// Small synchronous FIFO with a registered head; the head reads as zero while empty.
module if_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign pop_ok  = pop & ~empty;
    // A full FIFO may accept a push in the same cycle its head is popped.
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch.sv
// RV32I fetch stage: PC, in-order word fetch, instruction buffer and redirect flush.
// IFETCH_FAULT_EN adds ibus_err_i, fault entries and the halted state.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RstPC,
    parameter int          DEPTH    = 2
) (
    input logic      clk,
    input logic      rst,
    ifetch_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = CW + 2;

    logic [31:0]   pc;
    logic [CW-1:0] outst;
    logic [DW-1:0] discard;
    logic          halted;
    logic          grant;
    logic          accept;
    logic          pop;
    logic          fault_hit;
    logic [CW:0]   occ;

    fetch_entry_t  fe_din;
    fetch_entry_t  fe_dout;
    logic          fe_empty;
    logic          fe_full;
    logic [CW-1:0] fe_count;
    logic [31:0]   aq_dout;
    logic          aq_empty;
    logic          aq_full;
    logic [CW-1:0] aq_count;

    assign pop    = bus.inst_valid_o & bus.inst_ready_i & ~bus.redirect_i;
    assign occ    = {1'b0, outst} + {1'b0, fe_count} - {{CW{1'b0}}, pop};
    assign grant  = bus.ibus_req_o & bus.ibus_gnt_i;
    // Responses still owed to a flushed fetch stream are swallowed first.
    assign accept = bus.ibus_rvalid_i & (discard == '0);

    assign bus.ibus_req_o  = ~rst & ~bus.redirect_i & ~halted & (occ < (CW+1)'(DEPTH));
    assign bus.ibus_addr_o = pc;

`ifdef IFETCH_FAULT_EN
    assign fault_hit   = accept & bus.ibus_err_i;
    assign bus.fault_o = fe_dout.fault;

    always_ff @(posedge clk) begin
        if (rst || bus.redirect_i) halted <= 1'b0;
        else if (fault_hit)        halted <= 1'b1;
    end
`else
    assign fault_hit   = 1'b0;
    assign bus.fault_o = 1'b0;
    assign halted      = 1'b0;
`endif

    assign fe_din.fault = fault_hit;
    assign fe_din.addr  = aq_dout;
    assign fe_din.inst  = fault_hit ? INST_NOP : bus.ibus_rdata_i;

    assign bus.inst_valid_o = ~fe_empty;
    assign bus.inst_o       = fe_dout.inst;
    assign bus.addr_o       = fe_dout.addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            outst   <= '0;
            discard <= '0;
        end else if (bus.redirect_i) begin
            pc      <= word_align(bus.redirect_pc_i);
            outst   <= '0;
            discard <= discard + DW'(outst) + DW'(grant) - DW'(bus.ibus_rvalid_i);
        end else if (fault_hit) begin
            if (grant) pc <= pc + 32'd4;
            outst   <= '0;
            discard <= DW'(outst) + DW'(grant) - DW'(1);
        end else begin
            if (grant) pc <= pc + 32'd4;
            outst <= outst + CW'(grant) - CW'(accept);
            if (bus.ibus_rvalid_i && discard != '0) discard <= discard - 1'b1;
        end
    end

    if_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_i),
        .push  (accept),
        .din   (fe_din),
        .pop   (pop),
        .dout  (fe_dout),
        .full  (fe_full),
        .empty (fe_empty),
        .count (fe_count)
    );

    // Addresses of granted requests, matched to responses in order.
    if_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_i | fault_hit),
        .push  (grant),
        .din   (pc),
        .pop   (accept),
        .dout  (aq_dout),
        .full  (aq_full),
        .empty (aq_empty),
        .count (aq_count)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, fe_full, aq_full, aq_empty, aq_count, fe_dout.fault};

    assert property (@(posedge clk) disable iff (rst)
        bus.ibus_rvalid_i |-> (outst != '0 || discard != '0));

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: budgeted-grant memory model, directed phases, pop monitor.
module tb_ifetch;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_if bus_if ();

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic        fault;
        logic [31:0] addr;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    int          lat = 1;
    int          budget = 0;
    int          grants = 0;
    logic [31:0] err_addr = 32'h0000_0001;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always @(posedge clk) cyc++;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.fault = 1'b0;
            e.addr  = start + 32'(4 * i);
            e.inst  = memfn(e.addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Memory: grants while budget lasts, answers each grant lat cycles later.
    initial begin
        bus_if.ibus_gnt_i    = 1'b0;
        bus_if.ibus_rvalid_i = 1'b0;
        bus_if.ibus_rdata_i  = '0;
`ifdef IFETCH_FAULT_EN
        bus_if.ibus_err_i    = 1'b0;
`endif
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                bus_if.ibus_gnt_i    = 1'b0;
                bus_if.ibus_rvalid_i = 1'b0;
                continue;
            end
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                logic [31:0] a;
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                bus_if.ibus_rvalid_i = 1'b1;
                bus_if.ibus_rdata_i  = memfn(a);
`ifdef IFETCH_FAULT_EN
                bus_if.ibus_err_i    = (a == err_addr);
`endif
            end else begin
                bus_if.ibus_rvalid_i = 1'b0;
                bus_if.ibus_rdata_i  = '0;
`ifdef IFETCH_FAULT_EN
                bus_if.ibus_err_i    = 1'b0;
`endif
            end
            bus_if.ibus_gnt_i = (budget > 0);
            if (bus_if.ibus_req_o && bus_if.ibus_gnt_i) begin
                pend_addr.push_back(bus_if.ibus_addr_o);
                pend_due.push_back(cyc + lat);
                budget--;
                grants++;
            end
        end
    end

    // Monitor: every accepted head is compared against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus_if.inst_valid_o && bus_if.inst_ready_i && !bus_if.redirect_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop unexpected addr=%h inst=%h", bus_if.addr_o, bus_if.inst_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus_if.addr_o !== e.addr || bus_if.inst_o !== e.inst || bus_if.fault_o !== e.fault) begin
                        errors++;
                        $display("FAIL pop actual addr=%h inst=%h fault=%b required addr=%h inst=%h fault=%b",
                                 bus_if.addr_o, bus_if.inst_o, bus_if.fault_o, e.addr, e.inst, e.fault);
                    end
                end
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int          rst_cyc;
        int          g0;
        rst                  = 1'b1;
        bus_if.inst_ready_i  = 1'b1;
        bus_if.redirect_i    = 1'b0;
        bus_if.redirect_pc_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req", 32'(bus_if.ibus_req_o), 32'd0);
        check_eq("rst_valid", 32'(bus_if.inst_valid_o), 32'd0);
        check_eq("rst_inst", bus_if.inst_o, 32'd0);
        check_eq("rst_addr", bus_if.addr_o, 32'd0);
        check_eq("rst_fault", 32'(bus_if.fault_o), 32'd0);

        // Streaming from reset with a 1-cycle memory.
        @(negedge clk);
        expect_seq(32'h0, 8);
        budget  = 8;
        rst     = 1'b0;
        rst_cyc = cyc;
        wait_drain(60);
        check_eq("first_latency", 32'(first_pop - rst_cyc), 32'd2);
        check_eq("stream_span", 32'(last_pop - first_pop), 32'd7);

        // Backpressure: decode stalls for 10 cycles.
        @(negedge clk);
        bus_if.inst_ready_i = 1'b0;
        g0     = grants;
        budget = 6;
        expect_seq(32'h20, 6);
        repeat (10) @(negedge clk);
        #3;
        check_eq("stall_grants", 32'(grants - g0), 32'(DEPTH));
        check_eq("stall_valid", 32'(bus_if.inst_valid_o), 32'd1);
        check_eq("stall_addr", bus_if.addr_o, 32'h20);
        check_eq("stall_inst", bus_if.inst_o, memfn(32'h20));
        @(negedge clk);
        bus_if.inst_ready_i = 1'b1;
        wait_drain(60);

        // Grant withheld: request address must hold.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            check_eq("hold_req", 32'(bus_if.ibus_req_o), 32'd1);
            check_eq("hold_addr", bus_if.ibus_addr_o, 32'h38);
        end
        @(negedge clk);
        budget = 1;
        expect_seq(32'h38, 1);
        wait_drain(60);
        check_eq("after_one_grant", bus_if.ibus_addr_o, 32'h3C);

        // Redirect with two requests in flight on a slow memory.
        @(negedge clk);
        lat    = 3;
        budget = 2;
        @(negedge clk);
        @(negedge clk);
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0103;
        budget = 3;
        expect_seq(32'h100, 3);
        @(negedge clk);
        bus_if.redirect_i = 1'b0;
        #3;
        check_eq("redir_req", 32'(bus_if.ibus_req_o), 32'd1);
        check_eq("redir_addr", bus_if.ibus_addr_o, 32'h100);
        check_eq("redir_valid", 32'(bus_if.inst_valid_o), 32'd0);
        wait_drain(60);
        lat = 1;

        // PC wrap at the top of the address space.
        @(negedge clk);
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'hFFFF_FFFC;
        budget = 2;
        expect_seq(32'hFFFF_FFFC, 2);
        @(negedge clk);
        bus_if.redirect_i = 1'b0;
        #3;
        check_eq("wrap_top", bus_if.ibus_addr_o, 32'hFFFF_FFFC);
        @(negedge clk);
        #3;
        check_eq("wrap_zero", bus_if.ibus_addr_o, 32'h0);
        wait_drain(60);

`ifdef IFETCH_FAULT_EN
        // Bus error on 0x20 halts fetch until the next redirect.
        @(negedge clk);
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h10;
        budget   = 10;
        err_addr = 32'h20;
        expect_seq(32'h10, 4);
        begin
            exp_t e;
            e.fault = 1'b1;
            e.addr  = 32'h20;
            e.inst  = 32'h0000_0013;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus_if.redirect_i = 1'b0;
        wait_drain(60);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            check_eq("halted_req", 32'(bus_if.ibus_req_o), 32'd0);
        end
        @(negedge clk);
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h40;
        budget   = 2;
        err_addr = 32'h1;
        expect_seq(32'h40, 2);
        @(negedge clk);
        bus_if.redirect_i = 1'b0;
        wait_drain(60);
`endif

        repeat (5) @(negedge clk);
        check_eq("leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
